mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised N-port arbiter that lets several caches (I-cache, D-cache, future L2 refill or DMA ports) share one slow-memory port using the cache/slow-memory handshake: request held, one-cycle `mem_ready` pulse. It sits between the cache instances and the external memory interface in the top level, replacing the one-memory-port-per-cache arrangement. It supports fixed-priority or round-robin selection, registers the winning command, and returns data only to the granted requester.

## Interface
- `N_PORTS`, 2: number of requesting ports, ≥2.
- `ADDR_W`, 28: block address width (byte address bits [31:4]).
- `DATA_W`, 128: cache-line width.
- `ARB_MODE`, 0: 0 = fixed priority (port 0 highest); 1 = round-robin.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_read`  in  N_PORTS  per-port read request, held until its `req_ready`.
- `req_write`  in  N_PORTS  per-port write request, held until its `req_ready`.
- `req_addr`  in  N_PORTS*ADDR_W  flattened; port i is at [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  N_PORTS*DATA_W  flattened, same packing.
- `req_rdata`  out  DATA_W  broadcast read data; valid only with a `req_ready` bit.
- `req_ready`  out  N_PORTS  one-hot completion pulse.
- `mem_read`, `mem_write`  out  1  downstream command.
- `mem_addr`  out  ADDR_W  downstream address.
- `mem_wdata`  out  DATA_W  downstream write data.
- `mem_rdata`  in  DATA_W  downstream read data.
- `mem_ready`  in  1  downstream one-cycle completion pulse.
- `grant`  out  N_PORTS  one-hot current owner, zero when idle.
- `busy`  out  1  high in BUSY and RELEASE.

## Operation
- FSM states are IDLE, BUSY and RELEASE.
- **IDLE:**
  - Port i is requesting when `req_read[i] | req_write[i]`.
  - If any port requests, select a winner per `ARB_MODE`.
  - Register `grant`, `mem_addr`, `mem_wdata`, `mem_read`, `mem_write` from the winner, then go to BUSY.
  - If the winner asserts both read and write, it is treated as a write (`mem_write`=1, `mem_read`=0).
- **BUSY:**
  - Hold the latched command unchanged, ignoring any upstream changes.
  - On `mem_ready`: `req_ready` = `grant` and `req_rdata` = `mem_rdata`, both combinational and in the same cycle.
  - On that same edge, clear `mem_read`/`mem_write`, then go to RELEASE.
- **RELEASE:** one cycle. No command is issued and requests are not sampled; the completed port deasserts its request during this cycle. Clear `grant`, then go to IDLE.
- **Round-robin:**
  - A pointer holds the highest-priority index. It is updated to (winner+1) mod N_PORTS on each grant.
  - Search order is pointer, pointer+1, … with wrap-around.
- **Fixed priority:** the lowest index wins; the pointer is unused.
- `req_ready` is 0 outside BUSY. A `mem_ready` arriving in IDLE or RELEASE is ignored.
- `req_rdata` = `mem_rdata` at all times; consumers qualify it with `req_ready`.

## Timing
- **Reset (async assert):** state IDLE, pointer 0. All registered outputs are 0: `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `grant`, `busy`.
- **Reset mid-transfer:** the in-flight transfer is abandoned and no `req_ready` is produced.
- **Latency:** request visible in cycle t (IDLE) → `mem_*` and `grant` asserted at t+1.
- **Completion:** `mem_ready` in cycle r → `req_ready` in r, `mem_*` low at r+1 (RELEASE), IDLE at r+2, next command at r+3 at the earliest.
- **Simultaneous requests:** exactly one grant; the others wait with their request held.
- **Request/ready overlap:** a new request arriving in the same cycle as `mem_ready` is not considered until IDLE.

## Structure
- **Package `mem_arb_pkg`:**
  - state encoding (IDLE/BUSY/RELEASE)
  - `ARB_FIXED`=0, `ARB_RR`=1
  - default widths: 28 and 128
- **Sub-module `rr_select`:** combinational; inputs are the request vector, pointer and mode; outputs are a one-hot winner and its index. It is parametrised by N_PORTS and unit-tested on its own.
- The top module holds the FSM, pointer and command registers (~200 lines total).

## Test plan
- **Single read:** port 1 reads addr 0x0000ABC, memory readies 4 cycles later with 128'h1234.
  - `mem_read`=1, `mem_addr`=0x0000ABC from t+1.
  - `req_ready`=2'b10 for one cycle with `req_rdata`=128'h1234; no pulse on port 0.
- **Fixed priority, N=2:** both ports request at once → port 0 is served first, port 1 is issued at port 0's r+3.
- **Round-robin, N=4:** ports 0, 2, 3 request continuously → grant order 0, 2, 3, 0, 2; every gap between `mem_ready` and the next command is exactly 2 cycles.
- **Write and read-write conflict:** port 0 writes 0xFF..FF to 0x10. Then port 0 asserts read+write together.
  - First transfer: `mem_write`=1, `mem_wdata` held until ready.
  - Conflict transfer: issued as a write.
- **Async reset:** `rst_n` pulled low mid-BUSY, between clock edges → all outputs 0 immediately, no `req_ready`; after release, the pending request is re-granted cleanly.
- **Stray ready:** `mem_ready` pulsed in IDLE → no `req_ready`, state stays IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the slow-memory arbiter.
//   arb_state_t          : FSM encoding (IDLE / BUSY / RELEASE)
//   ARB_FIXED / ARB_RR   : values of the ARB_MODE parameter
//   DEF_ADDR_W / DEF_DATA_W : default block-address and cache-line widths
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

endpackage

// File: rtl/rr_select.sv
// Combinational winner selection for the memory arbiter.
//   req        in  N_PORTS  request vector
//   ptr        in  IDX_W    highest-priority index (round-robin only)
//   mode       in  1        0 = fixed priority from index 0, 1 = search from ptr
//   winner_oh  out N_PORTS  one-hot winner, zero when nothing requests
//   winner_idx out IDX_W    index of the winner (0 when nothing requests)
module rr_select #(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               mode,
  output logic [N_PORTS-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx
);

  logic [IDX_W-1:0] start;

  // start + k never exceeds 2*N_PORTS-2, so one subtraction wraps it
  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return (v >= N_PORTS) ? IDX_W'(v - N_PORTS) : IDX_W'(v);
  endfunction

  // Scan from the farthest candidate back to the start so the candidate
  // closest to the start position is the last (and winning) assignment.
  always_comb begin
    start      = mode ? ptr : '0;
    winner_idx = '0;
    winner_oh  = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (req[wrap_idx(int'(start) + k)]) winner_idx = wrap_idx(int'(start) + k);
    end
    if (|req) winner_oh[winner_idx] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter sharing one slow-memory port between several caches.
// Requests are held until their one-cycle req_ready pulse; the winning
// command is registered and held until mem_ready, then the arbiter spends
// one RELEASE cycle so the finished requester can drop its request.
//   clk, rst_n             clock, async active-low reset
//   req_read/req_write     in  per-port requests
//   req_addr/req_wdata     in  flattened per-port address / write data
//   req_rdata              out broadcast read data (qualify with req_ready)
//   req_ready              out one-hot completion pulse
//   mem_read/mem_write     out downstream command
//   mem_addr/mem_wdata     out downstream address / write data
//   mem_rdata/mem_ready    in  downstream read data / completion pulse
//   grant                  out one-hot current owner
//   busy                   out high in BUSY and RELEASE
//
// state   | meaning
// IDLE    | sampling requests, no command outstanding
// BUSY    | command issued, waiting for mem_ready
// RELEASE | completed port drops its request, grant cleared on exit
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_PORTS  = 2,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PORTS-1:0]         req_read,
  input  logic [N_PORTS-1:0]         req_write,
  input  logic [N_PORTS*ADDR_W-1:0]  req_addr,
  input  logic [N_PORTS*DATA_W-1:0]  req_wdata,
  output logic [DATA_W-1:0]          req_rdata,
  output logic [N_PORTS-1:0]         req_ready,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  output logic [N_PORTS-1:0]         grant,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_PORTS);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   ptr, win_idx;
  logic [N_PORTS-1:0] req_vec, win_oh;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_read, sel_write;
  logic               load_cmd, clr_cmd, clr_grant;

  assign req_vec   = req_read | req_write;
  assign req_rdata = mem_rdata;
  assign busy      = (state != ST_IDLE);

  rr_select #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_sel (
    .req        (req_vec),
    .ptr        (ptr),
    .mode       (ARB_MODE == ARB_RR),
    .winner_oh  (win_oh),
    .winner_idx (win_idx)
  );

  // One-hot mux of the winner's command fields
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_read  = 1'b0;
    sel_write = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (win_oh[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_read  = req_read[i];
        sel_write = req_write[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_cmd  = 1'b0;
    clr_cmd   = 1'b0;
    clr_grant = 1'b0;
    req_ready = '0;
    case (state)
      ST_IDLE: begin
        if (|req_vec) begin
          load_cmd  = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          req_ready = grant;
          clr_cmd   = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        clr_grant = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= '0;
    end else begin
      if (load_cmd) begin
        grant     <= win_oh;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        // read+write together is issued as a write
        mem_write <= sel_write;
        mem_read  <= sel_read & ~sel_write;
        if (ARB_MODE == ARB_RR) begin
          ptr <= (win_idx == IDX_W'(N_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      if (clr_cmd) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
      if (clr_grant) grant <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench: one fixed-priority and one round-robin
// arbiter, each with its own request generator, memory responder,
// transaction-level reference model and output monitor.
module tb_mem_arbiter;

  localparam int NP   = 4;
  localparam int AW   = 28;
  localparam int DW   = 128;
  localparam int NCYC = 700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit env_done [2];

  typedef struct {
    int            cyc;
    logic [NP-1:0] oh;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int            cyc;
    logic [NP-1:0] oh;
    logic [DW-1:0] rdata;
  } rsp_t;

  typedef struct {
    int            slot;
    int            port;
    int            kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } dreq_t;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // first pending port at or after start, wrapping around; -1 if none
  function automatic int pick(input bit p[NP], input int start);
    for (int k = 0; k < NP; k++) begin
      if (p[(start + k) % NP]) return (start + k) % NP;
    end
    return -1;
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_env
    localparam int MODE = d;

    logic             rst_n;
    logic [NP-1:0]    req_read, req_write, req_ready, grant;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [DW-1:0]    req_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]    mem_addr;
    logic             mem_read, mem_write, mem_ready, busy;

    mem_arbiter #(
      .N_PORTS  (NP),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .ARB_MODE (MODE)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_read  (req_read),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_rdata (req_rdata),
      .req_ready (req_ready),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .grant     (grant),
      .busy      (busy)
    );

    cmd_t exp_q[$];
    rsp_t rsp_q[$];
    int   cyc    = 0;
    bit   in_rst = 1'b1;

    // stimulus, memory responder and reference model
    initial begin : stim
      bit            pend [NP];
      int            kind [NP];
      logic [AW-1:0] pa [NP];
      logic [DW-1:0] pw [NP];
      dreq_t         dq[$];
      int            mptr, free_slot, issue_at, ready_at, drop_at, drop_port, cur_port, tx_n, w;
      bit            outstanding, rst_done;
      cmd_t          ec;
      rsp_t          er;

      rst_n = 1'b0;
      req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      for (int p = 0; p < NP; p++) begin
        pend[p] = 1'b0; kind[p] = 0; pa[p] = '0; pw[p] = '0;
      end
      mptr = 0; free_slot = 0; issue_at = 0; ready_at = 0; drop_at = -10;
      drop_port = 0; cur_port = 0; tx_n = 0; w = 0;
      outstanding = 1'b0; rst_done = 1'b0;

      dq.push_back('{slot: 2,  port: 1, kind: 0, addr: 28'h0000ABC, wd: 128'h0});
      dq.push_back('{slot: 12, port: 0, kind: 1, addr: 28'h10, wd: {DW{1'b1}}});
      dq.push_back('{slot: 24, port: 0, kind: 2, addr: 28'h10, wd: {4{32'hA5A5_5A5A}}});
      for (int p = 0; p < NP; p++)
        dq.push_back('{slot: 36, port: p, kind: 0, addr: AW'(28'h100 + p), wd: 128'h0});

      repeat (3) @(posedge clk);
      #1;
      check($sformatf("d%0d reset mem_read", d), 128'(mem_read), 128'(0));
      check($sformatf("d%0d reset mem_write", d), 128'(mem_write), 128'(0));
      check($sformatf("d%0d reset mem_addr", d), 128'(mem_addr), 128'(0));
      check($sformatf("d%0d reset mem_wdata", d), mem_wdata, 128'(0));
      check($sformatf("d%0d reset grant", d), 128'(grant), 128'(0));
      check($sformatf("d%0d reset busy", d), 128'(busy), 128'(0));
      #1;
      rst_n = 1'b1;
      in_rst = 1'b0;

      for (int s = 0; s < NCYC; s++) begin
        if (s > 0) begin
          @(posedge clk);
          cyc = cyc + 1;
          #2;
        end
        if (!rst_n) rst_n = 1'b1;
        else if (in_rst) in_rst = 1'b0;

        if (cyc == drop_at) pend[drop_port] = 1'b0;

        if (cyc < NCYC - 60) begin
          if (dq.size() > 0) begin
            while (dq.size() > 0 && cyc >= dq[0].slot && !pend[dq[0].port] &&
                   !(cyc == drop_at && dq[0].port == drop_port)) begin
              pend[dq[0].port] = 1'b1;
              kind[dq[0].port] = dq[0].kind;
              pa[dq[0].port]   = dq[0].addr;
              pw[dq[0].port]   = dq[0].wd;
              void'(dq.pop_front());
            end
          end else if (cyc >= 50) begin
            for (int p = 0; p < NP; p++) begin
              if (!pend[p] && !(cyc == drop_at && p == drop_port) && $urandom_range(0, 3) == 0) begin
                pend[p] = 1'b1;
                kind[p] = int'($urandom_range(0, 2));
                pa[p]   = AW'($urandom);
                pw[p]   = {$urandom, $urandom, $urandom, $urandom};
              end
            end
          end
        end

        for (int p = 0; p < NP; p++) begin
          req_read[p]  = pend[p] && kind[p] != 1;
          req_write[p] = pend[p] && kind[p] != 0;
          req_addr[p*AW +: AW]  = pa[p];
          req_wdata[p*DW +: DW] = pw[p];
        end

        // arbiter is free: the request set seen now is granted next cycle
        if (!outstanding && cyc >= free_slot) begin
          w = pick(pend, (MODE == 1) ? mptr : 0);
          if (w >= 0) begin
            ec.cyc   = cyc + 1;
            ec.oh    = NP'(1 << w);
            ec.rd    = (kind[w] == 0);
            ec.wr    = (kind[w] != 0);
            ec.addr  = pa[w];
            ec.wdata = pw[w];
            exp_q.push_back(ec);
            outstanding = 1'b1;
            cur_port = w;
            issue_at = cyc + 1;
            tx_n++;
            ready_at = cyc + 1 + ((tx_n == 1) ? 4 : int'($urandom_range(0, 4)));
            if (MODE == 1) mptr = (w + 1) % NP;
          end
        end

        mem_ready = 1'b0;
        if (outstanding && cyc == ready_at) begin
          mem_ready = 1'b1;
          mem_rdata = (tx_n == 1) ? 128'h1234 : {$urandom, $urandom, $urandom, $urandom};
          er.cyc   = cyc;
          er.oh    = NP'(1 << cur_port);
          er.rdata = mem_rdata;
          rsp_q.push_back(er);
          outstanding = 1'b0;
          free_slot   = cyc + 2;
          drop_at     = cyc + 1;
          drop_port   = cur_port;
        end else if (!outstanding && $urandom_range(0, 5) == 0) begin
          mem_ready = 1'b1;
          mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end

        // asynchronous reset in the middle of a transfer, between edges
        if (!rst_done && cyc >= 300 && outstanding && cyc >= issue_at && cyc < ready_at) begin
          #3;
          rst_n  = 1'b0;
          in_rst = 1'b1;
          #1;
          check($sformatf("d%0d areset mem_read", d), 128'(mem_read), 128'(0));
          check($sformatf("d%0d areset mem_write", d), 128'(mem_write), 128'(0));
          check($sformatf("d%0d areset mem_addr", d), 128'(mem_addr), 128'(0));
          check($sformatf("d%0d areset mem_wdata", d), mem_wdata, 128'(0));
          check($sformatf("d%0d areset grant", d), 128'(grant), 128'(0));
          check($sformatf("d%0d areset busy", d), 128'(busy), 128'(0));
          check($sformatf("d%0d areset req_ready", d), 128'(req_ready), 128'(0));
          exp_q.delete();
          rsp_q.delete();
          outstanding = 1'b0;
          mptr        = 0;
          free_slot   = cyc + 1;
          rst_done    = 1'b1;
        end
      end

      @(posedge clk);
      #4;
      check($sformatf("d%0d cmds left", d), 128'(exp_q.size()), 128'(0));
      check($sformatf("d%0d readies left", d), 128'(rsp_q.size()), 128'(0));
      check($sformatf("d%0d transfer open", d), 128'(outstanding), 128'(0));
      check($sformatf("d%0d async reset hit", d), 128'(rst_done), 128'(1));
      env_done[d] = 1'b1;
    end

    // monitor: compares DUT outputs against the scoreboard queues
    initial begin : mon
      cmd_t          cur;
      rsp_t          er;
      bit            cur_valid;
      int            last_r;
      logic [NP-1:0] last_oh;
      logic          cmd;

      cur_valid = 1'b0;
      last_r    = -10;
      last_oh   = '0;
      forever begin
        @(posedge clk);
        #3;
        if (in_rst) begin
          cur_valid = 1'b0;
          last_r    = -10;
          continue;
        end
        cmd = mem_read | mem_write;
        if (cmd) begin
          if (!cur_valid) begin
            if (exp_q.size() == 0) begin
              check($sformatf("d%0d unexpected cmd c%0d", d, cyc), 128'(cmd), 128'(0));
            end else begin
              cur = exp_q.pop_front();
              cur_valid = 1'b1;
              check($sformatf("d%0d cmd cycle", d), 128'(cyc), 128'(cur.cyc));
            end
          end
          if (cur_valid) begin
            check($sformatf("d%0d grant c%0d", d, cyc), 128'(grant), 128'(cur.oh));
            check($sformatf("d%0d mem_read c%0d", d, cyc), 128'(mem_read), 128'(cur.rd));
            check($sformatf("d%0d mem_write c%0d", d, cyc), 128'(mem_write), 128'(cur.wr));
            check($sformatf("d%0d mem_addr c%0d", d, cyc), 128'(mem_addr), 128'(cur.addr));
            check($sformatf("d%0d mem_wdata c%0d", d, cyc), mem_wdata, cur.wdata);
            check($sformatf("d%0d busy c%0d", d, cyc), 128'(busy), 128'(1));
          end
        end
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
          er = rsp_q.pop_front();
          check($sformatf("d%0d req_ready c%0d", d, cyc), 128'(req_ready), 128'(er.oh));
          check($sformatf("d%0d req_rdata c%0d", d, cyc), req_rdata, er.rdata);
          last_r    = cyc;
          last_oh   = er.oh;
          cur_valid = 1'b0;
        end else begin
          check($sformatf("d%0d no ready c%0d", d, cyc), 128'(req_ready), 128'(0));
        end
        if (!cmd) begin
          if (cyc == last_r + 1) begin
            check($sformatf("d%0d release grant c%0d", d, cyc), 128'(grant), 128'(last_oh));
            check($sformatf("d%0d release busy c%0d", d, cyc), 128'(busy), 128'(1));
          end else begin
            check($sformatf("d%0d idle grant c%0d", d, cyc), 128'(grant), 128'(0));
            check($sformatf("d%0d idle busy c%0d", d, cyc), 128'(busy), 128'(0));
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(env_done[0] && env_done[1]); i++) @(posedge clk);
    if (!(env_done[0] && env_done[1])) begin
      total++;
      bad++;
      $display("FAIL watchdog: envs done=%0d%0d want=11", env_done[1], env_done[0]);
    end
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
